// File: rtl/ones_count_ctrl.sv
// ones_count_ctrl: sequences the ones-counting data path and hands the count out on a valid/ready port
module ones_count_ctrl #(
  parameter int R1_SIZE = 8,
  parameter int R2_SIZE = 4
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  output logic               ready,
  output logic               busy,
  input  logic               zero,
  input  logic               msb,
  input  logic [R2_SIZE-1:0] count,
  output logic               load_regs,
  output logic               incr_r2,
  output logic               shift_left,
  output logic [R2_SIZE-1:0] result,
  output logic               result_valid,
  input  logic               result_ready
);
  typedef enum logic [2:0] {S_IDLE, S_1, S_2, S_3, S_DONE} state_t;
  state_t state, state_nxt;
  if (2**R2_SIZE <= R1_SIZE) begin : g_size_chk
    $error("ones_count_ctrl: R2_SIZE too small to hold a count of R1_SIZE ones");
  end
  // State register; the count is captured on the S_2 cycle that sees R1 empty
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state  <= S_IDLE;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_2 && zero) result <= count;
    end
  end
  // Next state: S_1 counts a one, S_2 tests for empty or shifts, S_3 routes on the bit shifted out
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start ? S_1 : S_IDLE;
      S_1:     state_nxt = S_2;
      S_2:     state_nxt = zero ? S_DONE : S_3;
      S_3:     state_nxt = msb ? S_1 : S_2;
      S_DONE:  state_nxt = result_ready ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end
  // Control decodes; gating with rstb keeps every output quiet while reset is held
  always_comb begin
    ready        = rstb && state == S_IDLE;
    busy         = rstb && (state == S_1 || state == S_2 || state == S_3);
    load_regs    = ready && start;
    incr_r2      = rstb && state == S_1;
    shift_left   = rstb && state == S_2 && !zero;
    result_valid = rstb && state == S_DONE;
  end
endmodule

// File: tb/tb_ones_count_ctrl.sv
// tb_ones_count_ctrl: scoreboard bench driving the controller through a behavioural data path
module tb_ones_count_ctrl;
  localparam int R1 = 8;
  localparam int R2 = 4;
  logic          clk, rstb, start, ready, busy, zero, msb;
  logic [R2-1:0] count, result;
  logic          load_regs, incr_r2, shift_left, result_valid, result_ready;
  logic [R1-1:0] data, r1;
  logic [R2-1:0] r2;
  logic          msb_q;
  typedef struct {int res; int lat; int inc; int sh;} exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  int t_acc = 0, n_inc = 0, n_sh = 0;
  logic rv_q = 0, rr_rand = 0;

  ones_count_ctrl #(.R1_SIZE(R1), .R2_SIZE(R2)) dut (
    .clk(clk), .rstb(rstb), .start(start), .ready(ready), .busy(busy),
    .zero(zero), .msb(msb), .count(count), .load_regs(load_regs),
    .incr_r2(incr_r2), .shift_left(shift_left), .result(result),
    .result_valid(result_valid), .result_ready(result_ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Data path the controller drives: shift register, counter, msb flop
  initial begin
    r1 = '0;
    r2 = '0;
    msb_q = 0;
  end
  always @(posedge clk) begin
    if (load_regs) begin
      r1 <= data;
      r2 <= '1;
    end else begin
      if (incr_r2) r2 <= r2 + 1'b1;
      if (shift_left) begin
        r1 <= r1 << 1;
        msb_q <= r1[R1-1];
      end
    end
  end
  assign zero  = (r1 == '0);
  assign msb   = msb_q;
  assign count = r2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Reference: count of ones; the scan stops once the lowest set bit has been shifted out
  function automatic exp_t model(input logic [R1-1:0] d);
    exp_t e;
    int ones = 0, sh = 0;
    for (int i = R1 - 1; i >= 0; i--)
      if (d[i]) begin
        ones++;
        sh = R1 - i;
      end
    e.res = ones;
    e.inc = ones + 1;
    e.sh  = sh;
    e.lat = 2 + 3 * ones + 2 * (sh - ones);
    return e;
  endfunction

  // Monitor: per-job pulse counts and latency, compared when result_valid rises
  always @(negedge clk) begin
    exp_t e;
    chk("one_hot_ctrl", int'($countones({load_regs, incr_r2, shift_left}) <= 1), 1);
    if (load_regs) begin
      t_acc = cyc + 1;
      n_inc = 0;
      n_sh  = 0;
    end
    if (incr_r2) n_inc++;
    if (shift_left) n_sh++;
    if (result_valid && !rv_q) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = sb.pop_front();
        chk("result", int'(result), e.res);
        chk("latency", cyc - t_acc, e.lat);
        chk("incr_pulses", n_inc, e.inc);
        chk("shift_pulses", n_sh, e.sh);
      end
    end
    rv_q = result_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_rand) result_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic issue(input logic [R1-1:0] d);
    int n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    data  = d;
    start = 1;
    sb.push_back(model(d));
  endtask

  task automatic go(input logic [R1-1:0] d);
    issue(d);
    tick();
    start = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 400) begin
      tick();
      n++;
    end
    if (sb.size() != 0 || !ready) chk("done_timeout", 0, 1);
  endtask

  initial begin
    logic [R2-1:0] r;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R2-1:0] r;
    int n;
    rstb = 0;
    start = 0;
    data = '0;
    result_ready = 1;
    #2;
    start = 1;
    #1;
    chk("rst_ctrl_quiet", int'({ready, busy, load_regs, incr_r2, shift_left, result_valid}), 0);
    chk("rst_result", int'(result), 0);
    start = 0;
    tick();
    rstb = 1;
    #1;
    chk("post_rst_ready", int'({ready, busy, result_valid}), 3'b100);

    issue(8'h00);
    #1 chk("zero_load", int'(load_regs), 1);
    tick();
    start = 0;
    #1 chk("zero_s1", int'({busy, incr_r2, shift_left}), 3'b110);
    tick();
    #1 chk("zero_s2", int'({busy, incr_r2, shift_left, result_valid}), 4'b1000);
    tick();
    #1 chk("zero_valid", int'({result_valid, result}), {1'b1, 4'd0});
    tick();
    #1 chk("zero_back_idle", int'({ready, result_valid}), 2'b10);

    go(8'hFF); wait_done();
    go(8'h80); wait_done();
    go(8'h01); wait_done();
    go(8'hA5); wait_done();

    result_ready = 0;
    go(8'hA5);
    n = 0;
    while (!result_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_valid_seen", int'(result_valid), 1);
    r = result;
    chk("bp_result", int'(r), 4);
    start = 1;
    data = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_hold", int'({result_valid, result, load_regs}), {1'b1, r, 1'b0});
      tick();
    end
    result_ready = 1;
    tick();
    sb.push_back(model(8'h3C));
    #1 chk("bp_restart", int'({ready, load_regs}), 2'b11);
    tick();
    start = 0;
    wait_done();

    go(8'hFF);
    n = 0;
    while (!shift_left && n < 100) begin
      tick();
      n++;
    end
    chk("rst_mid_shift_seen", int'(shift_left), 1);
    tick();
    rstb = 0;
    #1 chk("rst_mid_quiet", int'({ready, busy, load_regs, incr_r2, shift_left, result_valid, result}), 0);
    tick();
    rstb = 1;
    sb.delete();
    #1 chk("rst_mid_idle", int'({ready, result_valid, result}), {1'b1, 1'b0, 4'd0});
    go(8'h0F); wait_done();

    rr_rand = 1;
    for (int j = 0; j < 40; j++) begin
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) tick();
      go(R1'($urandom_range(0, 255)));
    end
    wait_done();
    rr_rand = 0;
    result_ready = 1;
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
